// File: rtl/de_stage.sv
// -----------------------------------------------------------------------------
// de_stage -- RV32I decode stage
//
// Decodes the instruction held in the fetch latch and reads its source
// registers. It owns the architectural register file and a busy-bit
// scoreboard, stalls fetch on read-after-write hazards, and squashes its own
// output on a branch mispredict. The result is registered into DE_latch_out,
// one clock after the instruction appears on FE_latch_in.
//
// Parameters
//   DBITS  register / datapath width (default 32)
//   NREGS  architectural register count (default 32), x0 reads as zero
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset
//   FE_latch_in      {valid, inst[31:0], PC[31:0], pcplus[31:0], inst_count[31:0]}
//   from_AGEX_to_DE  branch mispredict, flushes this stage
//   from_WB_to_DE    {wr_en, wr_reg[4:0], wr_data[31:0]} register write-back
//   from_DE_to_FE    stall request to fetch
//   DE_latch_out     {valid, inst, PC, pcplus, opclass[3:0], rd[4:0], wr_en,
//                     rs1_val, rs2_val, imm, inst_count}
//
// Build option
//   DE_WB_BYPASS_EN  when defined, a write-back in the same cycle is forwarded
//                    to the source operands instead of causing a stall.
// -----------------------------------------------------------------------------
module de_stage #(
  parameter int DBITS = 32,
  parameter int NREGS = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [128:0] FE_latch_in,
  input  logic         from_AGEX_to_DE,
  input  logic [37:0]  from_WB_to_DE,
  output logic         from_DE_to_FE,
  output logic [234:0] DE_latch_out
);

  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_ALU_R  = 4'd1,
    OP_ALU_I  = 4'd2,
    OP_LOAD   = 4'd3,
    OP_STORE  = 4'd4,
    OP_BRANCH = 4'd5,
    OP_JAL    = 4'd6,
    OP_JALR   = 4'd7,
    OP_LUI    = 4'd8,
    OP_AUIPC  = 4'd9
  } opclass_e;

  logic             fe_valid;
  logic [31:0]      fe_inst, fe_pc, fe_pcplus, fe_count;
  logic             mispred;
  logic             wb_we;
  logic [4:0]       wb_reg;
  logic [31:0]      wb_data;

  assign {fe_valid, fe_inst, fe_pc, fe_pcplus, fe_count} = FE_latch_in;
  assign mispred = from_AGEX_to_DE;
  assign {wb_we, wb_reg, wb_data} = from_WB_to_DE;

  logic [DBITS-1:0] rf_q [NREGS];
  logic [DBITS-1:0] rf_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [234:0]     out_q, out_d;

  opclass_e    opclass;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, dec_wr_en;
  logic        fwd1, fwd2;
  logic [31:0] rs1_val, rs2_val;
  logic        stall;

  // Instruction decode: opclass, immediate and operand usage. Encodings with
  // a reserved funct3/funct7 combination fall back to OP_NONE.
  always_comb begin
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opcode  = fe_inst[6:0];
    funct3  = fe_inst[14:12];
    funct7  = fe_inst[31:25];
    opclass = OP_NONE;
    imm     = 32'd0;
    case (opcode)
      7'b0110011: if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    opclass = OP_ALU_R;
      7'b0010011: if (funct3 == 3'b001 ? funct7 == 7'h00 :
                      funct3 == 3'b101 ? (funct7 == 7'h00 || funct7 == 7'h20) : 1'b1)
                    opclass = OP_ALU_I;
      7'b0000011: if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111)
                    opclass = OP_LOAD;
      7'b0100011: if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010)
                    opclass = OP_STORE;
      7'b1100011: if (funct3 != 3'b010 && funct3 != 3'b011)
                    opclass = OP_BRANCH;
      7'b1101111: opclass = OP_JAL;
      7'b1100111: if (funct3 == 3'b000) opclass = OP_JALR;
      7'b0110111: opclass = OP_LUI;
      7'b0010111: opclass = OP_AUIPC;
      default:    opclass = OP_NONE;
    endcase
    case (opclass)
      OP_ALU_I, OP_LOAD, OP_JALR: imm = {{20{fe_inst[31]}}, fe_inst[31:20]};
      OP_STORE:  imm = {{20{fe_inst[31]}}, fe_inst[31:25], fe_inst[11:7]};
      OP_BRANCH: imm = {{19{fe_inst[31]}}, fe_inst[31], fe_inst[7], fe_inst[30:25], fe_inst[11:8], 1'b0};
      OP_LUI, OP_AUIPC: imm = {fe_inst[31:12], 12'd0};
      OP_JAL:    imm = {{11{fe_inst[31]}}, fe_inst[31], fe_inst[19:12], fe_inst[20], fe_inst[30:21], 1'b0};
      default:   imm = 32'd0;
    endcase
    rs1     = fe_inst[19:15];
    rs2     = fe_inst[24:20];
    use_rs1 = opclass inside {OP_ALU_R, OP_ALU_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
    use_rs2 = opclass inside {OP_ALU_R, OP_STORE, OP_BRANCH};
    dec_wr_en = (opclass inside {OP_ALU_R, OP_ALU_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
                && (fe_inst[11:7] != 5'd0);
    rd = dec_wr_en ? fe_inst[11:7] : 5'd0;
  end

  // Operand read and hazard detection. A same-cycle write-back is only
  // forwarded when the bypass is built in; otherwise the busy bit is still
  // set this cycle and the consumer waits until the register file holds it.
  always_comb begin
`ifdef DE_WB_BYPASS_EN
    fwd1 = wb_we && (wb_reg != 5'd0) && (wb_reg == rs1);
    fwd2 = wb_we && (wb_reg != 5'd0) && (wb_reg == rs2);
`else
    fwd1 = 1'b0;
    fwd2 = 1'b0;
`endif
    rs1_val = 32'd0;
    rs2_val = 32'd0;
    if (use_rs1 && rs1 != 5'd0) rs1_val = fwd1 ? wb_data : 32'(rf_q[rs1]);
    if (use_rs2 && rs2 != 5'd0) rs2_val = fwd2 ? wb_data : 32'(rf_q[rs2]);
    stall = fe_valid && !mispred && !reset &&
            ((use_rs1 && rs1 != 5'd0 && busy_q[rs1] && !fwd1) ||
             (use_rs2 && rs2 != 5'd0 && busy_q[rs2] && !fwd2));
  end

  // Next state for the output latch, scoreboard and register file. The
  // scoreboard set is applied last so it overrides a same-cycle clear.
  always_comb begin
    out_d  = 235'd0;
    busy_d = busy_q;
    rf_d   = rf_q;
    if (wb_we && wb_reg != 5'd0) begin
      rf_d[wb_reg]   = DBITS'(wb_data);
      busy_d[wb_reg] = 1'b0;
    end
    if (mispred) begin
      // Squash the writer sitting in our output latch so it never blocks a reader.
      if (out_q[234] && out_q[128]) busy_d[out_q[133:129]] = 1'b0;
    end else if (fe_valid && !stall) begin
      out_d = {1'b1, fe_inst, fe_pc, fe_pcplus, opclass, rd, dec_wr_en,
               rs1_val, rs2_val, imm, fe_count};
      if (dec_wr_en) busy_d[rd] = 1'b1;
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      busy_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      out_q  <= out_d;
      busy_q <= busy_d;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign from_DE_to_FE = stall;
  assign DE_latch_out  = out_q;

endmodule

// File: tb/tb_de_stage.sv
// -----------------------------------------------------------------------------
// tb_de_stage -- directed self-checking bench for de_stage
//
// Inputs are driven just after the falling edge, the combinational stall is
// checked before the next rising edge, and DE_latch_out is checked at the
// following falling edge. Expected vectors are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_de_stage;

  logic         clk;
  logic         reset;
  logic [128:0] FE_latch_in;
  logic         from_AGEX_to_DE;
  logic [37:0]  from_WB_to_DE;
  logic         from_DE_to_FE;
  logic [234:0] DE_latch_out;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] ADD_X2_X1   = 32'h00108133;
  localparam logic [31:0] BEQ_M8      = 32'hFE000CE3;
  localparam logic [31:0] ADDI_X6_X2  = 32'h00110313;
  localparam logic [31:0] LUI_X3      = 32'h123451B7;
  localparam logic [31:0] ADDI_X7_X3  = 32'h00118393;
  localparam logic [31:0] ADD_X9_X0   = 32'h000004B3;
  localparam logic [31:0] ADDI_X10_X1 = 32'h00308513;
  localparam logic [31:0] JAL_X1_16   = 32'h010000EF;
  localparam logic [31:0] ILLEGAL     = 32'hFFFFFFFF;

  de_stage #(.DBITS(32), .NREGS(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .FE_latch_in     (FE_latch_in),
    .from_AGEX_to_DE (from_AGEX_to_DE),
    .from_WB_to_DE   (from_WB_to_DE),
    .from_DE_to_FE   (from_DE_to_FE),
    .DE_latch_out    (DE_latch_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected DE_latch_out for a valid decoded instruction
  function automatic logic [234:0] expOut(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] cnt, input logic [3:0] opc,
                                          input logic [4:0] rd, input logic wren,
                                          input logic [31:0] r1, input logic [31:0] r2,
                                          input logic [31:0] imm);
    return {1'b1, inst, pc, pc + 32'd4, opc, rd, wren, r1, r2, imm, cnt};
  endfunction

  task automatic applyStimulus(input logic valid, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] cnt, input logic mp, input logic wbe,
                               input logic [4:0] wbr, input logic [31:0] wbd);
    FE_latch_in     = {valid, inst, pc, pc + 32'd4, cnt};
    from_AGEX_to_DE = mp;
    from_WB_to_DE   = {wbe, wbr, wbd};
  endtask

  task automatic checkOutput(input string tag, input logic [234:0] obs, input logic [234:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);
    #3;
    checkOutput("reset_out", DE_latch_out, 235'd0);
    checkOutput("reset_stall", 235'(from_DE_to_FE), 235'd0);
    @(negedge clk);
    reset = 1'b0;

    // addi x1,x0,5
    applyStimulus(1'b1, ADDI_X1_5, 32'h100, 32'd1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("addi_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("addi_out", DE_latch_out, expOut(ADDI_X1_5, 32'h100, 32'd1, 4'd2, 5'd1, 1'b1, 32'd0, 32'd0, 32'd5));

    // add x2,x1,x1 hits busy x1
    applyStimulus(1'b1, ADD_X2_X1, 32'h104, 32'd2, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("raw_stall", 235'(from_DE_to_FE), 235'd1);
    step();
    checkOutput("raw_bubble", DE_latch_out, 235'd0);

    // write-back of x1 = 5 in the same cycle the consumer waits
    applyStimulus(1'b1, ADD_X2_X1, 32'h104, 32'd2, 1'b0, 1'b1, 5'd1, 32'd5);
`ifdef DE_WB_BYPASS_EN
    #1 checkOutput("wb_stall_byp", 235'(from_DE_to_FE), 235'd0);
    step();
`else
    #1 checkOutput("wb_stall_nobyp", 235'(from_DE_to_FE), 235'd1);
    step();
    checkOutput("wb_bubble_nobyp", DE_latch_out, 235'd0);
    applyStimulus(1'b1, ADD_X2_X1, 32'h104, 32'd2, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("rf_stall_nobyp", 235'(from_DE_to_FE), 235'd0);
    step();
`endif
    checkOutput("add_out", DE_latch_out, expOut(ADD_X2_X1, 32'h104, 32'd2, 4'd1, 5'd2, 1'b1, 32'd5, 32'd5, 32'd0));

    // beq x0,x0,-8
    applyStimulus(1'b1, BEQ_M8, 32'h108, 32'd3, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("beq_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("beq_valid", 235'(DE_latch_out[234]), 235'd1);
    checkOutput("beq_opclass", 235'(DE_latch_out[137:134]), 235'd5);
    checkOutput("beq_wren", 235'(DE_latch_out[128]), 235'd0);
    checkOutput("beq_imm", 235'(DE_latch_out[63:32]), 235'hFFFFFFF8);

    // x2 still busy from the add: a reader of x2 stalls
    applyStimulus(1'b1, ADDI_X6_X2, 32'h10C, 32'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("x2_busy_stall", 235'(from_DE_to_FE), 235'd1);
    // an invalid fetch slot never stalls and produces a bubble
    applyStimulus(1'b0, ADDI_X6_X2, 32'h10C, 32'd4, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("invalid_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("invalid_out", DE_latch_out, 235'd0);

    // lui x3 then mispredict
    applyStimulus(1'b1, LUI_X3, 32'h200, 32'd5, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    checkOutput("lui_out", DE_latch_out, expOut(LUI_X3, 32'h200, 32'd5, 4'd8, 5'd3, 1'b1, 32'd0, 32'd0, 32'h12345000));
    applyStimulus(1'b1, ADDI_X7_X3, 32'h204, 32'd6, 1'b1, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("mispred_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("mispred_out", DE_latch_out, 235'd0);
    applyStimulus(1'b1, ADDI_X7_X3, 32'h300, 32'd7, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("x3_cleared_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("addi_x7_opclass", 235'(DE_latch_out[137:134]), 235'd2);
    checkOutput("addi_x7_rd", 235'(DE_latch_out[133:129]), 235'd7);
    checkOutput("addi_x7_rs1", 235'(DE_latch_out[127:96]), 235'd0);
    checkOutput("addi_x7_imm", 235'(DE_latch_out[63:32]), 235'd1);

    // write-back to x0 is ignored; x0 reads stay zero
    applyStimulus(1'b1, ADD_X9_X0, 32'h304, 32'd8, 1'b0, 1'b1, 5'd0, 32'hDEADBEEF);
    #1 checkOutput("x0_wb_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("x0_same_cycle", DE_latch_out, expOut(ADD_X9_X0, 32'h304, 32'd8, 4'd1, 5'd9, 1'b1, 32'd0, 32'd0, 32'd0));
    applyStimulus(1'b1, ADD_X9_X0, 32'h308, 32'd9, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("x0_later_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("x0_later", DE_latch_out, expOut(ADD_X9_X0, 32'h308, 32'd9, 4'd1, 5'd9, 1'b1, 32'd0, 32'd0, 32'd0));

    // register file read of x1 (written earlier)
    applyStimulus(1'b1, ADDI_X10_X1, 32'h30C, 32'd10, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    checkOutput("rf_read_x1", DE_latch_out, expOut(ADDI_X10_X1, 32'h30C, 32'd10, 4'd2, 5'd10, 1'b1, 32'd5, 32'd0, 32'd3));

    // illegal encoding
    applyStimulus(1'b1, ILLEGAL, 32'h310, 32'd11, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    checkOutput("illegal_opclass", 235'(DE_latch_out[137:134]), 235'd0);
    checkOutput("illegal_wren", 235'(DE_latch_out[128]), 235'd0);
    checkOutput("illegal_imm", 235'(DE_latch_out[63:32]), 235'd0);

    // jal x1,+16 makes x1 busy again
    applyStimulus(1'b1, JAL_X1_16, 32'h400, 32'd12, 1'b0, 1'b0, 5'd0, 32'd0);
    step();
    checkOutput("jal_out", DE_latch_out, expOut(JAL_X1_16, 32'h400, 32'd12, 4'd6, 5'd1, 1'b1, 32'd0, 32'd0, 32'd16));

    // reset in the middle of a stall, between clock edges
    applyStimulus(1'b1, ADD_X2_X1, 32'h404, 32'd13, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 checkOutput("pre_reset_stall", 235'(from_DE_to_FE), 235'd1);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_reset_stall", 235'(from_DE_to_FE), 235'd0);
    checkOutput("async_reset_out", DE_latch_out, 235'd0);
    @(negedge clk);
    reset = 1'b0;
    #1 checkOutput("post_reset_stall", 235'(from_DE_to_FE), 235'd0);
    step();
    checkOutput("post_reset_out", DE_latch_out, expOut(ADD_X2_X1, 32'h404, 32'd13, 4'd1, 5'd2, 1'b1, 32'd0, 32'd0, 32'd0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
